sevenseg_scan_driver: RTL and testbench

//  Multi-digit, time-multiplexed 7-segment display driver. Holds a NUM_DIGITS hex value and scans the digits.

---
 rtl/sevenseg_pkg.sv | 35 +++
 rtl/sevenseg_glyph_decode.sv | 11 +
 rtl/sevenseg_scan_driver.sv | 155 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Glyphs are active low, bit order g..a = [6:0].
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n sits at bits [7n+6:7n]; digit 0 is the least significant slice.
  localparam logic [16*7-1:0] GLYPH_ROM = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH_ROM[int'(nibble)*7 +: 7];
  endfunction

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-coherent double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int IDX_W = min1_clog2(NUM_DIGITS);
  localparam int CNT_W = min1_clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]        count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;
  logic                    tick, wrap;

  logic [3:0]            digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_eff;
  logic [3:0]            nib_sel;
  logic [6:0]            glyph;

`ifdef LEADING_ZERO_BLANK_EN
  // zero_up[i]: digits i..top are all zero with no dp; bit NUM_DIGITS is the sentinel.
  logic [NUM_DIGITS:1] zero_up;
  assign zero_up[NUM_DIGITS] = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi] = disp_data_q[gi*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (gi == 0) begin : g_lsd
      assign blank_eff[gi] = disp_blank_q[gi];
    end else begin : g_upper
      assign zero_up[gi]   = (digit_nib[gi] == 4'h0) && !disp_dp_q[gi] && zero_up[gi+1];
      assign blank_eff[gi] = disp_blank_q[gi] | zero_up[gi];
    end
`else
    assign blank_eff[gi] = disp_blank_q[gi];
`endif
  end

  assign nib_sel = digit_nib[idx_q];

  sevenseg_glyph_decode u_decode (
    .nibble_i (nib_sel),
    .seg_o    (glyph)
  );

  always_comb begin
    tick         = (count_q == LAST_CNT);
    wrap         = tick && (idx_q == LAST_IDX);
    count_d      = tick ? '0 : count_q + 1'b1;
    idx_d        = idx_q;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pending_d    = pending_q;

    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    if (load) begin
      sh_data_d  = data_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      pending_d  = 1'b1;
    end

    // A load coinciding with the wrap bypasses the shadow so it is not a frame late.
    if (wrap) begin
      if (load) begin
        disp_data_d  = data_in;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
      end else if (pending_q) begin
        disp_data_d  = sh_data_q;
        disp_dp_d    = sh_dp_q;
        disp_blank_d = sh_blank_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    seg_d = blank_eff[idx_q] ? SEG_BLANK : glyph;
    dp_d  = blank_eff[idx_q] ? 1'b1 : ~disp_dp_q[idx_q];
    an_d  = '1;
    if ((int'(count_q) >= BLANK_CYCLES) && !blank_eff[idx_q]) an_d[idx_q] = 1'b0;
    fs_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fs_q         <= 1'b0;
    end else begin
      count_q      <= count_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign an_out      = an_q;
  assign pending     = pending_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench: random and directed loads against a time-arithmetic display model.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        pending;
  logic        frame_start;

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .pending     (pending),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] glyph_tab [16];

  // Model: m_k counts rising edges since reset release; slot and digit follow from it.
  int          m_k;
  logic [15:0] m_data, m_sh_data;
  logic [3:0]  m_dp, m_blank, m_sh_dp, m_sh_blank;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_pend, e_fs;

  function automatic logic digit_dark(input int d);
    logic dark;
    dark = m_blank[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      logic allz;
      allz = 1'b1;
      for (int j = d; j < ND; j++)
        if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) allz = 1'b0;
      dark = dark | allz;
    end
`endif
    return dark;
  endfunction

  task automatic model_reset();
    m_k = 0; m_data = '0; m_sh_data = '0; m_dp = '0; m_blank = '0;
    m_sh_dp = '0; m_sh_blank = '0; m_pend = 1'b0;
  endtask

  // Called at a falling edge: drives inputs, predicts the outputs of the next rising edge.
  task automatic advance(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    int   idx, pos;
    logic dark, wrap;
    load = ld; data_in = d; dp_in = dp; blank_in = bl;
    if (ld) $display("load k=%0d data=%h dp=%b blank=%b", m_k, d, dp, bl);
    idx  = (m_k / SD) % ND;
    pos  = m_k % SD;
    dark = digit_dark(idx);
    e_seg = dark ? 7'h7F : glyph_tab[m_data[4*idx +: 4]];
    e_dp  = dark ? 1'b1 : ~m_dp[idx];
    e_an  = 4'hF;
    if (pos >= BC && !dark) e_an[idx] = 1'b0;
    wrap = (m_k % FRAME) == FRAME - 1;
    e_fs = wrap;
    if (ld) begin m_sh_data = d; m_sh_dp = dp; m_sh_blank = bl; m_pend = 1'b1; end
    if (wrap) begin
      if (ld) begin m_data = d; m_dp = dp; m_blank = bl; end
      else if (m_pend) begin m_data = m_sh_data; m_dp = m_sh_dp; m_blank = m_sh_blank; end
      m_pend = 1'b0;
    end
    e_pend = m_pend;
    m_k++;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({seg_out, dp_out, an_out, pending, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values got %b want %b", {seg_out, dp_out, an_out, pending, frame_start},
               {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_idle();
    int n_an0;
    n_an0 = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL scan_idle k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
      if (c < FRAME && an_out == 4'b1110) n_an0++;
    end
    n_cmp++;
    if (n_an0 !== SD - BC) begin
      n_bad++;
      $display("FAIL scan_digit0_active_cycles got %0d want %0d", n_an0, SD - BC);
    end
  endtask

  task automatic test_mid_frame_load();
    logic [6:0] want [4];
    want[0] = 7'b0001110; want[1] = 7'b0001000; want[2] = 7'b0100100; want[3] = 7'b1111001;
    while (m_k % FRAME != 13) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL mid_load_pre k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
    end
    advance(1'b1, 16'h12AF, 4'h0, 4'h0);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load_pending got %b want 1", pending);
    end
    for (int c = 0; c < FRAME + 18; c++) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL mid_load k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
      if (c >= 18 && (m_k - 1) % SD == 5) begin
        n_cmp++;
        if (seg_out !== want[((m_k - 1) / SD) % ND] || pending !== 1'b0) begin
          n_bad++;
          $display("FAIL mid_load_glyph digit=%0d got %b/%b want %b/0", ((m_k - 1) / SD) % ND,
                   seg_out, pending, want[((m_k - 1) / SD) % ND]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int saw_one;
    saw_one = 0;
    while (m_k % FRAME != 3) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL b2b_pre k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
    end
    advance(1'b1, 16'h1111, 4'h0, 4'h0);
    advance(1'b0, '0, '0, '0);
    advance(1'b1, 16'h2222, 4'h0, 4'h0);
    for (int c = 0; c < FRAME + 26; c++) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL b2b k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
      if (c >= 26) begin
        if (seg_out == 7'b1111001) saw_one++;
        if ((m_k - 1) % SD == 5) begin
          n_cmp++;
          if (seg_out !== 7'b0100100) begin
            n_bad++;
            $display("FAIL b2b_glyph k=%0d got %b want 0100100", m_k - 1, seg_out);
          end
        end
      end
    end
    n_cmp++;
    if (saw_one !== 0) begin
      n_bad++;
      $display("FAIL b2b_stale_glyph got %0d cycles of 1 want 0", saw_one);
    end
  endtask

  task automatic test_wrap_load();
    while (m_k % FRAME != FRAME - 1) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL wrap_load_pre k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
    end
    advance(1'b1, 16'h0005, 4'h0, 4'h0);
    n_cmp++;
    if ({pending, frame_start} !== 2'b01) begin
      n_bad++;
      $display("FAIL wrap_load_edge pending/frame_start got %b want 01", {pending, frame_start});
    end
    for (int c = 0; c < FRAME; c++) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}
          || pending !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_load k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
      if (c == 5) begin
        n_cmp++;
        if ({seg_out, an_out} !== {7'b0010010, 4'b1110}) begin
          n_bad++;
          $display("FAIL wrap_load_digit0 got %b want %b", {seg_out, an_out}, {7'b0010010, 4'b1110});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      advance(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), 4'($urandom & 32'h5));
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL random k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    int d3_lit;
    for (int pass = 0; pass < 2; pass++) begin
      d3_lit = 0;
      advance(1'b1, 16'h0050, (pass == 0) ? 4'b0000 : 4'b1000, 4'h0);
      while (m_k % FRAME != 0) advance(1'b0, 16'h0050, 4'h0, 4'h0);
      for (int c = 0; c < FRAME; c++) begin
        advance(1'b0, '0, '0, '0);
        n_cmp++;
        if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
          n_bad++;
          $display("FAIL lzb k=%0d got %b want %b", m_k - 1,
                   {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
        end
        if (c >= 3 * SD && an_out[3] == 1'b0) d3_lit++;
        if (pass == 1 && c == 3 * SD + 5) begin
          n_cmp++;
          if ({seg_out, dp_out} !== {7'b1000000, 1'b0}) begin
            n_bad++;
            $display("FAIL lzb_digit3_dp got %b want %b", {seg_out, dp_out}, {7'b1000000, 1'b0});
          end
        end
        if (c == 2 * SD + 5) begin
          n_cmp++;
          if (seg_out !== ((pass == 0) ? 7'h7F : 7'b1000000)) begin
            n_bad++;
            $display("FAIL lzb_digit2 pass=%0d got %b", pass, seg_out);
          end
        end
      end
      n_cmp++;
      if (d3_lit !== ((pass == 0) ? 0 : SD - BC)) begin
        n_bad++;
        $display("FAIL lzb_digit3_active pass=%0d got %0d cycles", pass, d3_lit);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    advance(1'b1, 16'h9C3E, 4'b0010, 4'b0100);
    while (m_k % FRAME != SD * 2 + 4) advance(1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg_out, dp_out, an_out, pending, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset got %b want %b", {seg_out, dp_out, an_out, pending, frame_start},
               {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < FRAME + 4; c++) begin
      advance(1'b0, '0, '0, '0);
      n_cmp++;
      if ({seg_out, dp_out, an_out, pending, frame_start} !== {e_seg, e_dp, e_an, e_pend, e_fs}) begin
        n_bad++;
        $display("FAIL post_reset k=%0d got %b want %b", m_k - 1,
                 {seg_out, dp_out, an_out, pending, frame_start}, {e_seg, e_dp, e_an, e_pend, e_fs});
      end
      if (c == 5) begin
        n_cmp++;
        if ({seg_out, an_out, pending} !== {7'b1000000, 4'b1110, 1'b0}) begin
          n_bad++;
          $display("FAIL post_reset_digit0 got %b want %b", {seg_out, an_out, pending},
                   {7'b1000000, 4'b1110, 1'b0});
        end
      end
    end
  endtask

  initial begin
    glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();
    test_reset();
    test_scan_idle();
    test_mid_frame_load();
    test_back_to_back();
    test_wrap_load();
    test_random();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
